// File: rtl/qft_measure_if.sv
// Handshake and data bundle between the QFT block, the measurement
// stage and whatever consumes the measurement result.
interface qft_measure_if #(
  parameter int IN_W = 13
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] in_r0;
  logic signed [IN_W-1:0] in_r1;
  logic signed [IN_W-1:0] in_r2;
  logic signed [IN_W-1:0] in_r3;
  logic signed [IN_W-1:0] in_i0;
  logic signed [IN_W-1:0] in_i1;
  logic signed [IN_W-1:0] in_i2;
  logic signed [IN_W-1:0] in_i3;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_idx;
  logic [2*IN_W-1:0]      out_pmax;
  logic [2*IN_W+1:0]      out_total;
  logic                   out_tie;

  modport master (
    output in_valid, in_r0, in_r1, in_r2, in_r3,
    output in_i0, in_i1, in_i2, in_i3, out_ready,
    input  in_ready, out_valid, out_idx, out_pmax,
    input  out_total, out_tie
  );

  modport slave (
    input  in_valid, in_r0, in_r1, in_r2, in_r3,
    input  in_i0, in_i1, in_i2, in_i3, out_ready,
    output in_ready, out_valid, out_idx, out_pmax,
    output out_total, out_tie
  );
endinterface

// File: rtl/qft_measure.sv
// Serial squared-magnitude measurement of a 4-point QFT output vector:
// one element per cycle, reports argmax, max, total and tie flag.
module qft_measure #(
  parameter int IN_W = 13
) (
  input logic         clk,
  input logic         rst_n,
  qft_measure_if.slave bus
);
  localparam int PW = 2 * IN_W;
  localparam int TW = PW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t nxt;

  logic signed [IN_W-1:0] rr [4];
  logic signed [IN_W-1:0] ii [4];
  logic [1:0]             k;
  logic [PW-1:0]          mx;
  logic [TW-1:0]          tot;
  logic [1:0]             idx;
  logic                   tie;

  logic [1:0]             o_idx;
  logic [PW-1:0]          o_pmax;
  logic [TW-1:0]          o_tot;
  logic                   o_tie;

  logic                   acc;
  logic signed [PW-1:0]   rx;
  logic signed [PW-1:0]   ix;
  logic signed [PW-1:0]   rsq;
  logic signed [PW-1:0]   isq;
  logic [PW-1:0]          psq;
  logic [PW-1:0]          nmx;
  logic [TW-1:0]          ntot;
  logic [1:0]             nidx;
  logic                   ntie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) nxt = CALC;
      CALC:    if (k == 2'd3) nxt = DONE;
      DONE:    if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign acc = (state == IDLE) && bus.in_valid;

  // Sign-extend before squaring so -2^(IN_W-1) squares exactly.
  assign rx  = {{IN_W{rr[k][IN_W-1]}}, rr[k]};
  assign ix  = {{IN_W{ii[k][IN_W-1]}}, ii[k]};
  assign rsq = rx * rx;
  assign isq = ix * ix;
  assign psq = $unsigned(rsq) + $unsigned(isq);

  always_comb begin
    nmx  = mx;
    nidx = idx;
    ntie = tie;
    ntot = tot + TW'(psq);
    if (k == 2'd0) begin
      nmx  = psq;
      nidx = 2'd0;
      ntie = 1'b0;
      ntot = TW'(psq);
    end else if (psq > mx) begin
      nmx  = psq;
      nidx = k;
      ntie = 1'b0;
    end else if (psq == mx) begin
      ntie = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        rr[n] <= '0;
        ii[n] <= '0;
      end
      k      <= '0;
      mx     <= '0;
      tot    <= '0;
      idx    <= '0;
      tie    <= 1'b0;
      o_idx  <= '0;
      o_pmax <= '0;
      o_tot  <= '0;
      o_tie  <= 1'b0;
    end else if (acc) begin
      rr[0] <= bus.in_r0;
      rr[1] <= bus.in_r1;
      rr[2] <= bus.in_r2;
      rr[3] <= bus.in_r3;
      ii[0] <= bus.in_i0;
      ii[1] <= bus.in_i1;
      ii[2] <= bus.in_i2;
      ii[3] <= bus.in_i3;
      k     <= '0;
      mx    <= '0;
      tot   <= '0;
      idx   <= '0;
      tie   <= 1'b0;
    end else if (state == CALC) begin
      k   <= k + 2'd1;
      mx  <= nmx;
      tot <= ntot;
      idx <= nidx;
      tie <= ntie;
      if (k == 2'd3) begin
        o_idx  <= nidx;
        o_pmax <= nmx;
        o_tot  <= ntot;
        o_tie  <= ntie;
      end
    end
  end

  assign bus.out_idx   = o_idx;
  assign bus.out_pmax  = o_pmax;
  assign bus.out_total = o_tot;
  assign bus.out_tie   = o_tie;
endmodule

// File: tb/tb_qft_measure.sv
// Directed bench for qft_measure: literal expectations per vector plus a
// queue-based model checked every cycle the result is presented.
module tb_qft_measure;
  localparam int W = 13;

  typedef int vec_t [4];
  typedef struct {
    int     idx;
    longint pmax;
    longint tot;
    bit     tie;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nassert = 0;
  int   nfail = 0;
  exp_t exp_q [$];

  qft_measure_if #(.IN_W(W)) bus ();

  qft_measure #(.IN_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(vec_t r, vec_t i);
    longint p [4];
    exp_t e;
    e.tot = 0;
    for (int n = 0; n < 4; n++) begin
      p[n] = longint'(r[n]) * r[n] + longint'(i[n]) * i[n];
      e.tot += p[n];
    end
    e.idx = 0;
    for (int n = 1; n < 4; n++)
      if (p[n] > p[e.idx]) e.idx = n;
    e.pmax = p[e.idx];
    e.tie = 1'b0;
    for (int n = 0; n < 4; n++)
      if (n != e.idx && p[n] == e.pmax) e.tie = 1'b1;
    return e;
  endfunction

  task automatic chk(string nm, longint act, longint req);
    nassert++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model queue
  int calc_cnt = 0;
  bit prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", longint'(bus.in_ready), 1);
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_pmax", longint'(bus.out_pmax), 0);
      calc_cnt = 0;
      prev_ov = 1'b0;
    end else if (bus.out_valid) begin
      chk("done_in_ready", longint'(bus.in_ready), 0);
      if (!prev_ov) chk("latency", calc_cnt, 4);
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("sb_idx", longint'(bus.out_idx), exp_q[0].idx);
        chk("sb_pmax", longint'(bus.out_pmax), exp_q[0].pmax);
        chk("sb_total", longint'(bus.out_total), exp_q[0].tot);
        chk("sb_tie", longint'(bus.out_tie), longint'(exp_q[0].tie));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      calc_cnt = 0;
      prev_ov = 1'b1;
    end else begin
      if (!bus.in_ready) calc_cnt++;
      else calc_cnt = 0;
      prev_ov = 1'b0;
    end
  end

  task automatic drive(vec_t r, vec_t i);
    bus.in_r0 = W'(r[0]);
    bus.in_r1 = W'(r[1]);
    bus.in_r2 = W'(r[2]);
    bus.in_r3 = W'(r[3]);
    bus.in_i0 = W'(i[0]);
    bus.in_i1 = W'(i[1]);
    bus.in_i2 = W'(i[2]);
    bus.in_i3 = W'(i[3]);
  endtask

  task automatic send(vec_t r, vec_t i, bit scramble);
    vec_t rr;
    vec_t ri;
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_send", longint'(bus.in_ready), 1);
    drive(r, i);
    bus.in_valid = 1'b1;
    exp_q.push_back(model(r, i));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (scramble) begin
      for (int m = 0; m < 4; m++) begin
        rr[m] = int'($urandom_range(8191)) - 4096;
        ri[m] = int'($urandom_range(8191)) - 4096;
      end
      drive(rr, ri);
    end
    chk("busy_after_accept", longint'(bus.in_ready), 0);
  endtask

  task automatic get(int eidx, longint epmax, longint etot, bit etie,
                     int hold);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_seen", longint'(bus.out_valid), 1);
    chk("lit_idx", longint'(bus.out_idx), eidx);
    chk("lit_pmax", longint'(bus.out_pmax), epmax);
    chk("lit_total", longint'(bus.out_total), etot);
    chk("lit_tie", longint'(bus.out_tie), longint'(etie));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_valid", longint'(bus.out_valid), 1);
      chk("bp_in_ready", longint'(bus.in_ready), 0);
      chk("bp_total", longint'(bus.out_total), etot);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after_hs", longint'(bus.in_ready), 1);
    chk("valid_after_hs", longint'(bus.out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive('{0, 0, 0, 0}, '{0, 0, 0, 0});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_in_ready", longint'(bus.in_ready), 1);
    chk("idle_out_valid", longint'(bus.out_valid), 0);

    send('{100, 0, -300, 0}, '{0, 0, 400, 0}, 1'b0);
    get(2, 250000, 260000, 1'b0, 0);

    send('{-4096, -4096, -4096, -4096}, '{-4096, -4096, -4096, -4096}, 1'b0);
    get(0, 33554432, 134217728, 1'b1, 0);

    send('{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0);
    get(0, 0, 0, 1'b1, 0);

    send('{0, 5, 0, -5}, '{3, 0, 4, 0}, 1'b0);
    get(1, 25, 75, 1'b1, 0);

    send('{7, -8, 1, 2}, '{1, 1, 1, 1}, 1'b0);
    get(1, 65, 122, 1'b0, 10);
    send('{-1, 2, -3, 4}, '{4, -3, 2, -1}, 1'b0);
    get(0, 17, 60, 1'b1, 0);

    send('{300, -200, 0, 50}, '{-100, 0, 250, 60}, 1'b1);
    get(0, 100000, 208600, 1'b0, 2);

    send('{-4096, -4096, -4096, -4096}, '{-4096, -4096, -4096, -4096}, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_in_ready", longint'(bus.in_ready), 1);
    chk("mid_rst_out_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_pmax", longint'(bus.out_pmax), 0);
    chk("mid_rst_total", longint'(bus.out_total), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("no_stale_valid", longint'(bus.out_valid), 0);
    end
    send('{0, 0, 0, -4096}, '{0, 0, 0, 0}, 1'b0);
    get(3, 16777216, 16777216, 1'b0, 0);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end
endmodule
